mux_param_rr: RTL
=================

// Module: mux_param_rr
// PURPOSE
//  Parametrised N-channel, WIDTH-bit multiplexer; successor to the fixed 4:1 combinational mux.
//  Registered output stage with valid/ready handshake on every input channel and on the output.
//  Two channel-selection modes: direct select, or round-robin scan over valid channels.
//  Sits between multiple producer channels and a single downstream consumer.
// PARAMETERS
//  WIDTH     2   data width per channel, >=1
//  CHANNELS  4   number of input channels, >=2
//  SEL_W     $clog2(CHANNELS)   localparam; width of select, out_chan and the RR pointer
// PORTS
//  clk        in   1               rising-edge clock; single clock domain
//  rst        in   1               asynchronous, active-high reset
//  in_data    in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel valid
//  in_ready   out  CHANNELS        per-channel ready (combinational); at most one bit high
//  mode       in   1               0 = direct select, 1 = round-robin
//  select     in   SEL_W           channel index, used only when mode=0
//  out_data   out  WIDTH           registered output data
//  out_valid  out  1               registered output valid
//  out_ready  in   1               downstream ready
//  out_chan   out  SEL_W           registered index of the channel that supplied out_data
// BEHAVIOUR
//  - Reset (async): out_data=0, out_valid=0, out_chan=0, RR pointer ptr=0.
//  - load = !out_valid | out_ready. The output register accepts a new word when load=1.
//  - Mode 0: g=select. in_ready[g]=load; all other in_ready bits are 0.
//    If select>=CHANNELS, no grant is made and in_ready is all 0.
//  - Mode 1: g = first channel with in_valid=1, searching ptr, ptr+1, ..., wrapping modulo CHANNELS.
//    in_ready[g]=load only when some in_valid bit is high. With no valid channel, in_ready is all 0.
//  - Transfer happens when in_valid[g] & in_ready[g]. On that clock edge:
//    out_data<=in_data[g], out_chan<=g, out_valid<=1.
//    In mode 1 only, ptr<=(g==CHANNELS-1)?0:g+1. The pointer is held in mode 0.
//  - If out_ready=1 and there is no transfer, out_valid<=0; out_data and out_chan hold their values.
//  - Latency: 1 cycle from transfer to out_valid. Full throughput (1 word/cycle) while out_ready=1.
//  - Backpressure: with out_valid=1 and out_ready=0, out_data and out_chan are stable and all in_ready=0.
//  - A mode or select change takes effect combinationally in the same cycle. ptr is retained across mode changes.
//  - Reset asserted mid-transfer: the pending word is dropped, no in_ready is granted, and the registers return to reset values immediately.
//  - in_data and in_valid of non-granted channels are ignored; no data is lost because those channels see no ready.
// CONFIGURATION
//  Macro MUX_PARAM_RR_SEL_ERR_EN:
//  - Defined: adds port sel_err (out, 1). sel_err is a sticky register, reset to 0.
//    It is set on the first edge where mode=0, select>=CHANNELS and |in_valid=1.
//    It is cleared only by rst.
//  - Undefined: the sel_err port and its logic are absent. Out-of-range select silently grants nothing.
//  - With CHANNELS a power of two, select can never be out of range; sel_err stays 0.
// TESTING
//  1 Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately.
//  2 Mode 0, CH=4, W=2, in_data={11,10,01,00}, all valid, select=0..3, out_ready=1
//    -> one cycle later out_data=00,01,10,11 and out_chan=select.
//  3 Mode 1, all 4 valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
//  4 Mode 1, ptr=1, only in_valid[3] and [0] set -> grant 3, then 0; ptr ends at 1.
//  5 Backpressure: out_ready=0 for 3 cycles while out_valid=1
//    -> in_ready=0, out_data stable; out_ready=1 -> next word loads the same cycle.
//  6 CH=5 with MUX_PARAM_RR_SEL_ERR_EN: mode 0, select=6, in_valid=1
//    -> no in_ready, out_valid stays 0, sel_err=1 until rst.

Source files
------------

// File: rtl/mux_param_rr.sv
// Parametrised N-channel registered mux with valid/ready on every channel and direct or round-robin selection.
// Optional feature macro: MUX_PARAM_RR_SEL_ERR_EN adds a sticky sel_err output for out-of-range direct selects.
module mux_param_rr #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
`ifdef MUX_PARAM_RR_SEL_ERR_EN
    ,
    output logic                      sel_err
`endif
);

    logic [WIDTH-1:0] chan_data [CHANNELS];

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             load;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting at ptr; descending loop so the nearest valid channel wins.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        load = !out_valid_q || out_ready;
        if (mode) begin
            grant    = rr_grant;
            grant_ok = rr_found;
        end else begin
            grant    = select;
            grant_ok = int'(select) < CHANNELS;
        end
    end

    // Ready is suppressed while reset is held so nothing is granted mid-reset.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant) == i) begin
                grant_data = chan_data[i];
                if (grant_ok && load && !rst) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
        xfer = |(in_ready & in_valid);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (int'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

`ifdef MUX_PARAM_RR_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q;
        if (!mode && (int'(select) >= CHANNELS) && (|in_valid)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule
